// File: rtl/nvboard_io_core_pkg.sv
// nvboard_io_core shared constants and helpers.
// Seven-segment font, PS/2 framing and display codes.
package nvboard_io_core_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] BRK_CODE  = 8'hF0;
   localparam int         FRAME_LEN = 11;

   // a..g active-high, indexed by hex digit
   localparam logic [15:0][6:0] SEG_FONT = {
      7'h71, 7'h79, 7'h5E, 7'h39,
      7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66,
      7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   function automatic logic [7:0] hex_seg(input logic [3:0] d);
      return ~{1'b0, SEG_FONT[d]};
   endfunction

   // start=0, stop=1, odd parity over data+parity
   function automatic logic frame_ok(
      input logic [FRAME_LEN-1:0] f
   );
      return !f[0] && f[10] && (^f[9:1]);
   endfunction

endpackage

// File: rtl/nvboard_io_core_if.sv
// Board pin bundle for nvboard_io_core.
// master = board side, slave = core side.
interface nvboard_io_core_if;

   logic [4:0]  btn;
   logic [7:0]  sw;
   logic        ps2_clk;
   logic        ps2_data;
   logic [15:0] ledr;
   logic [7:0]  seg0;
   logic [7:0]  seg1;
   logic [7:0]  seg2;
   logic [7:0]  seg3;
   logic [7:0]  seg4;
   logic [7:0]  seg5;
   logic [7:0]  seg6;
   logic [7:0]  seg7;

   modport master (
      output btn, sw, ps2_clk, ps2_data,
      input  ledr,
      input  seg0, seg1, seg2, seg3,
      input  seg4, seg5, seg6, seg7
   );

   modport slave (
      input  btn, sw, ps2_clk, ps2_data,
      output ledr,
      output seg0, seg1, seg2, seg3,
      output seg4, seg5, seg6, seg7
   );

endinterface

// File: rtl/nvb_ps2_rx.sv
// PS/2 receiver: synchronizer, 11-bit frame check, timeout.
// Emits one-cycle byte_valid / frame_err pulses.
module nvb_ps2_rx
   import nvboard_io_core_pkg::*;
#(
   parameter int TIMEOUT = 20000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err
);

   logic [2:0]           clk_sync;
   logic [1:0]           data_sync;
   logic [FRAME_LEN-2:0] shreg;
   logic [3:0]           bit_cnt;
   logic [31:0]          to_cnt;
   logic                 fall;
   logic [FRAME_LEN-1:0] frame;

   assign fall  = clk_sync[2] & ~clk_sync[1];
   assign frame = {data_sync[1], shreg};

   // sync flops reset high so reset never fakes a falling edge
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_sync   <= 3'b111;
         data_sync  <= 2'b11;
         shreg      <= '0;
         bit_cnt    <= '0;
         to_cnt     <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         clk_sync   <= {clk_sync[1:0], ps2_clk};
         data_sync  <= {data_sync[0], ps2_data};
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall) begin
            shreg  <= frame[FRAME_LEN-1:1];
            to_cnt <= '0;
            if (bit_cnt == 4'(FRAME_LEN - 1)) begin
               bit_cnt <= '0;
               if (frame_ok(frame)) begin
                  rx_byte    <= frame[8:1];
                  byte_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end else begin
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (clk_sync[1] && bit_cnt != 4'd0) begin
            if (to_cnt == 32'(TIMEOUT - 1)) begin
               bit_cnt <= '0;
               to_cnt  <= '0;
            end else begin
               to_cnt <= to_cnt + 32'd1;
            end
         end else begin
            to_cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/nvboard_io_core.sv
// nvboard I/O core: LEDs, PS/2 key tracking, hex display.
// All outputs registered, one cycle behind internal state.
module nvboard_io_core
   import nvboard_io_core_pkg::*;
#(
   parameter int LED_DIV     = 5000000,
   parameter int PS2_TIMEOUT = 20000
) (
   input logic              clk,
   input logic              rst,
   nvboard_io_core_if.slave io
);

   logic [31:0] div_cnt;
   logic [7:0]  run;
   logic [7:0]  rx_byte;
   logic        byte_valid;
   logic        frame_err;
   logic [7:0]  raw;
   logic [7:0]  cur;
   logic [7:0]  press_cnt;
   logic [7:0]  err_cnt;
   logic        brk;
   logic        held;

   nvb_ps2_rx #(.TIMEOUT(PS2_TIMEOUT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (io.ps2_clk),
      .ps2_data   (io.ps2_data),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         div_cnt <= '0;
         run     <= 8'h01;
         io.ledr <= 16'h0100;
      end else begin
         if (div_cnt == 32'(LED_DIV - 1)) begin
            div_cnt <= '0;
            run     <= {run[6:0], run[7]};
         end else begin
            div_cnt <= div_cnt + 32'd1;
         end
         io.ledr <= {run[7:5], run[4:0] ^ io.btn, io.sw};
      end
   end

   // typematic repeats of the held key are not new presses
   always_ff @(posedge clk) begin
      if (rst) begin
         raw       <= '0;
         cur       <= '0;
         press_cnt <= '0;
         err_cnt   <= '0;
         brk       <= 1'b0;
         held      <= 1'b0;
      end else begin
         if (frame_err && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
         end
         if (byte_valid) begin
            raw <= rx_byte;
            if (rx_byte == BRK_CODE) begin
               brk <= 1'b1;
            end else if (brk) begin
               brk <= 1'b0;
               if (rx_byte == cur) held <= 1'b0;
            end else begin
               if (!held || rx_byte != cur) begin
                  press_cnt <= press_cnt + 8'd1;
               end
               cur  <= rx_byte;
               held <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         io.seg0 <= SEG_BLANK;
         io.seg1 <= SEG_BLANK;
         io.seg2 <= SEG_BLANK;
         io.seg3 <= SEG_BLANK;
         io.seg4 <= SEG_BLANK;
         io.seg5 <= SEG_BLANK;
         io.seg6 <= SEG_BLANK;
         io.seg7 <= SEG_BLANK;
      end else begin
         io.seg0 <= held ? hex_seg(cur[3:0]) : SEG_BLANK;
         io.seg1 <= held ? hex_seg(cur[7:4]) : SEG_BLANK;
         io.seg2 <= hex_seg(err_cnt[3:0]);
         io.seg3 <= hex_seg(err_cnt[7:4]);
         io.seg4 <= hex_seg(press_cnt[3:0]);
         io.seg5 <= hex_seg(press_cnt[7:4]);
         io.seg6 <= hex_seg(raw[3:0]);
         io.seg7 <= hex_seg(raw[7:4]);
      end
   end

endmodule

// File: tb/tb_nvboard_io_core.sv
// Bench for nvboard_io_core: per-cycle check against a
// behavioural model, plus literal checkpoints.
module tb_nvboard_io_core;

   localparam int LED_DIV = 4;
   localparam int TMO     = 50;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   nvboard_io_core_if io ();

   nvboard_io_core #(
      .LED_DIV     (LED_DIV),
      .PS2_TIMEOUT (TMO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   logic [7:0] font [16] = '{
      8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
      8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
   };

   int n_chk  = 0;
   int n_fail = 0;

   int          k = 0;
   logic        ledr_valid = 1'b0;
   logic [15:0] exp_ledr = 16'h0;
   logic        settled = 1'b0;
   logic        rand_io = 1'b0;

   logic [7:0] m_raw = 0, m_cur = 0, m_press = 0, m_err = 0;
   logic       m_brk = 0, m_held = 0;

   task automatic chk8(input string nm, input logic [7:0] a,
                       input logic [7:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e,
                  $time);
      end
   endtask

   task automatic chk16(input string nm, input logic [15:0] a,
                        input logic [15:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, a, e,
                  $time);
      end
   endtask

   function automatic logic [7:0] dig(input logic [7:0] v,
                                      input bit hi);
      return hi ? font[v[7:4]] : font[v[3:0]];
   endfunction

   // LED model: run = 01 rotated once per LED_DIV active cycles
   always @(posedge clk) begin
      logic [7:0] r;
      ledr_valid = 1'b1;
      if (rst) begin
         k = 0;
         exp_ledr = 16'h0100;
      end else begin
         r = 8'h01;
         repeat ((k / LED_DIV) % 8) r = {r[6:0], r[7]};
         exp_ledr = {r[7:5], r[4:0] ^ io.btn, io.sw};
         k++;
      end
   end

   always @(posedge clk) begin
      #2;
      if (ledr_valid) chk16("ledr", io.ledr, exp_ledr);
      if (settled) begin
         chk8("seg0", io.seg0, m_held ? dig(m_cur, 0) : 8'hFF);
         chk8("seg1", io.seg1, m_held ? dig(m_cur, 1) : 8'hFF);
         chk8("seg2", io.seg2, dig(m_err, 0));
         chk8("seg3", io.seg3, dig(m_err, 1));
         chk8("seg4", io.seg4, dig(m_press, 0));
         chk8("seg5", io.seg5, dig(m_press, 1));
         chk8("seg6", io.seg6, dig(m_raw, 0));
         chk8("seg7", io.seg7, dig(m_raw, 1));
      end
   end

   task automatic tick();
      @(negedge clk);
      if (rand_io) begin
         io.sw  = 8'($urandom);
         io.btn = 5'($urandom);
      end
   endtask

   task automatic do_reset();
      settled = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      m_raw = 0; m_cur = 0; m_press = 0; m_err = 0;
      m_brk = 0; m_held = 0;
      settled = 1'b1;
   endtask

   function automatic logic [10:0] mk(input logic [7:0] b,
      input bit bad_par, input bit bad_stop, input bit bad_start);
      return {~bad_stop, (~^b) ^ bad_par, b, bad_start};
   endfunction

   task automatic model_frame(input logic [10:0] f);
      logic [7:0] b;
      b = f[8:1];
      if (f[0] == 1'b0 && f[10] == 1'b1 && (^f[9:1]) == 1'b1) begin
         m_raw = b;
         if (b == 8'hF0) m_brk = 1;
         else if (m_brk) begin
            m_brk = 0;
            if (b == m_cur) m_held = 0;
         end else begin
            if (!m_held || b != m_cur) m_press = m_press + 8'd1;
            m_cur = b;
            m_held = 1;
         end
      end else if (m_err != 8'hFF) begin
         m_err = m_err + 8'd1;
      end
   endtask

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         io.ps2_data = f[i];
         repeat (2) tick();
         io.ps2_clk = 1'b0;
         repeat (4) tick();
         io.ps2_clk = 1'b1;
         repeat (2) tick();
      end
      io.ps2_data = 1'b1;
   endtask

   task automatic send(input logic [10:0] f);
      settled = 1'b0;
      send_bits(f, 11);
      repeat (10) tick();
      model_frame(f);
      settled = 1'b1;
      tick();
   endtask

   task automatic key(input logic [7:0] b);
      send(mk(b, 0, 0, 0));
   endtask

   logic [7:0] exp_hi [9] = '{
      8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1E
   };

   initial begin
      logic [7:0] b;
      int kind;
      io.btn = 5'h0;
      io.sw = 8'hA5;
      io.ps2_clk = 1'b1;
      io.ps2_data = 1'b1;
      do_reset();

      for (int i = 0; i < 36; i++) begin
         tick();
         if (i == 0) begin
            chk8("rst_seg0", io.seg0, 8'hFF);
            chk8("rst_seg1", io.seg1, 8'hFF);
            chk8("rst_seg2", io.seg2, 8'hC0);
            chk8("rst_seg7", io.seg7, 8'hC0);
         end
         if (i % 4 == 0)
            chk16("run_step", io.ledr, {exp_hi[i / 4], 8'hA5});
         if (i == 31) io.btn = 5'h1F;
         if (i == 32) io.btn = 5'h0;
      end

      key(8'h1C);
      chk8("mk_seg1", io.seg1, 8'hF9);
      chk8("mk_seg0", io.seg0, 8'hC6);
      chk8("mk_seg4", io.seg4, 8'hF9);
      chk8("mk_seg6", io.seg6, 8'hC6);
      key(8'h1C);
      key(8'hF0);
      key(8'h1C);
      chk8("brk_seg4", io.seg4, 8'hF9);
      chk8("brk_seg0", io.seg0, 8'hFF);
      chk8("brk_seg1", io.seg1, 8'hFF);
      chk8("brk_seg7", io.seg7, 8'hF9);

      send(mk(8'h1C, 1, 0, 0));
      send(mk(8'h55, 0, 1, 0));
      chk8("err_seg2", io.seg2, 8'hA4);
      chk8("err_seg3", io.seg3, 8'hC0);
      chk8("err_seg6", io.seg6, 8'hC6);
      chk8("err_seg4", io.seg4, 8'hF9);

      send_bits(mk(8'h29, 0, 0, 0), 5);
      repeat (200) tick();
      key(8'h29);
      chk8("tmo_seg2", io.seg2, 8'hA4);
      chk8("tmo_seg1", io.seg1, 8'hA4);
      chk8("tmo_seg0", io.seg0, 8'h90);

      send_bits(mk(8'h77, 0, 0, 0), 5);
      do_reset();
      key(8'h29);
      chk8("rmf_seg0", io.seg0, 8'h90);
      chk8("rmf_seg4", io.seg4, 8'hF9);
      chk8("rmf_seg2", io.seg2, 8'hC0);

      rand_io = 1'b1;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 4))
            0: b = 8'h1C;
            1: b = 8'h29;
            2: b = 8'hF0;
            3: b = m_cur;
            default: b = 8'($urandom);
         endcase
         kind = $urandom_range(0, 6);
         send(mk(b, kind == 0, kind == 1, kind == 2));
      end

      do_reset();
      for (int i = 0; i < 255; i++) key((i % 2 == 0) ? 8'h11 : 8'h22);
      chk8("pff_seg5", io.seg5, 8'h8E);
      chk8("pff_seg4", io.seg4, 8'h8E);
      key(8'h22);
      chk8("pwrap_seg5", io.seg5, 8'hC0);
      chk8("pwrap_seg4", io.seg4, 8'hC0);

      for (int i = 0; i < 260; i++) send(mk(8'h1C, 1, 0, 0));
      chk8("esat_seg3", io.seg3, 8'h8E);
      chk8("esat_seg2", io.seg2, 8'h8E);
      chk8("esat_seg6", io.seg6, 8'hA4);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
